// File: rtl/seven_seg_reader_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_reader_pkg
//   Shared definitions for the seven-segment readback monitor:
//     - FSM state encoding (IDLE=0, TRACK=1, HELD=2)
//     - the 16 active-high hex glyphs (bit0=a ... bit6=g). This is the same
//       table the display decoder uses, so both directions share one
//       definition.
//     - hex_glyph(): maps a 4-bit value to its active-high glyph.
// -----------------------------------------------------------------------------
package seven_seg_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/seven_seg_reader_seg_pattern_to_hex.sv
// -----------------------------------------------------------------------------
// seg_pattern_to_hex
//   Combinational inverse of the hex-to-segment decoder.
//   Ports:
//     seg    in  7  active-high segment pattern (bit0=a ... bit6=g)
//     legal  out 1  pattern is one of the 16 hex glyphs
//     blank  out 1  no segment lit
//     value  out 4  hex value of the glyph (0 when not legal)
// -----------------------------------------------------------------------------
module seg_pattern_to_hex
    import seven_seg_reader_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] value
);

    always_comb begin
        legal = 1'b0;
        value = 4'h0;
        blank = (seg == 7'h00);
        // Glyphs are distinct, so at most one entry can match.
        for (int i = 0; i < 16; i++) begin
            if (seg == hex_glyph(4'(i))) begin
                legal = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_seg_reader.sv
// -----------------------------------------------------------------------------
// seven_seg_reader
//   Readback monitor for a multiplexed, active-low seven-segment bus. Samples
//   the segment lines and digit enables, waits for STABLE_CYCLES identical
//   samples, then maps the pattern back to a hex digit for the enabled digit.
//   Ports:
//     clk          in   clock
//     rst_n        in   asynchronous active-low reset
//     seg_n        in   7   active-low segments (bit0=a ... bit6=g)
//     digit_en_n   in   NUM_DIGITS active-low digit enables
//     clear        in   synchronous clear of digits/digit_valid/err_sticky
//     digits       out  4*NUM_DIGITS recovered values, digit i at [4i+3:4i]
//     digit_valid  out  NUM_DIGITS   digit i holds a committed legal value
//     update       out  one-cycle pulse on each legal commit
//     update_idx   out  IDX_W digit index of the last update/bad_pattern
//     bad_pattern  out  one-cycle pulse on an illegal committed pattern
//     err_sticky   out  set by bad_pattern, cleared by clear or reset
// -----------------------------------------------------------------------------
module seven_seg_reader
    import seven_seg_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4,
    localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   digit_en_n,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic [IDX_W-1:0]        update_idx,
    output logic                    bad_pattern,
    output logic                    err_sticky
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam int SMP_W = NUM_DIGITS + 7;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    // ---------------- input stage ----------------
    logic [SMP_W-1:0] sample_d, sample_q;
    logic [SMP_W-1:0] prev_q;    // sample seen by the FSM on the previous cycle

    always_comb begin
        sample_d = {digit_en_n, seg_n};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q <= '1;
            prev_q   <= '1;
        end else begin
            sample_q <= sample_d;
            prev_q   <= sample_q;
        end
    end

    logic [NUM_DIGITS-1:0] en;
    logic [6:0]            seg;
    logic                  one_hot;
    logic                  same;
    logic [IDX_W-1:0]      idx;

    assign en      = ~sample_q[SMP_W-1:7];
    assign seg     = ~sample_q[6:0];
    assign one_hot = (en != '0) && ((en & (en - NUM_DIGITS'(1))) == '0);
    assign same    = (sample_q == prev_q);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (en[i]) idx = IDX_W'(i);
        end
    end

    logic       pat_legal;
    logic       pat_blank;
    logic [3:0] pat_value;

    seg_pattern_to_hex u_lookup (
        .seg   (seg),
        .legal (pat_legal),
        .blank (pat_blank),
        .value (pat_value)
    );

    // ---------------- stability FSM ----------------
    state_t           state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (!one_hot) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TRACK;
                    cnt_d   = CNT_W'(1);
                end
                ST_TRACK: begin
                    if (same) begin
                        if (cnt_q < CNT_TARGET) cnt_d = cnt_q + 1'b1;
                    end else begin
                        cnt_d = CNT_W'(1);
                    end
                end
                ST_HELD: begin
                    if (!same) begin
                        state_d = ST_TRACK;
                        cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
            // Reaching the target (including a fresh start when the target
            // is 1) commits once and parks in HELD until the tuple changes.
            if (state_d == ST_TRACK && cnt_d == CNT_TARGET) begin
                commit  = 1'b1;
                state_d = ST_HELD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ---------------- result registers ----------------
    logic [4*NUM_DIGITS-1:0] digits_d, digits_q;
    logic [NUM_DIGITS-1:0]   valid_d, valid_q;
    logic                    update_d, update_q;
    logic [IDX_W-1:0]        update_idx_d, update_idx_q;
    logic                    bad_d, bad_q;
    logic                    err_d, err_q;

    always_comb begin
        digits_d     = digits_q;
        valid_d      = valid_q;
        update_d     = 1'b0;
        update_idx_d = update_idx_q;
        bad_d        = 1'b0;
        err_d        = err_q;
        if (clear) begin
            // A commit landing on the same edge is dropped entirely.
            digits_d = '0;
            valid_d  = '0;
            err_d    = 1'b0;
        end else if (commit) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (en[i]) begin
                    if (pat_legal) begin
                        digits_d[4*i +: 4] = pat_value;
                        valid_d[i]         = 1'b1;
                    end else begin
                        // Blank keeps the old value but marks it stale.
                        valid_d[i] = 1'b0;
                    end
                end
            end
            if (pat_legal) begin
                update_d     = 1'b1;
                update_idx_d = idx;
            end else if (!pat_blank) begin
                bad_d        = 1'b1;
                update_idx_d = idx;
                err_d        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q     <= '0;
            valid_q      <= '0;
            update_q     <= 1'b0;
            update_idx_q <= '0;
            bad_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            digits_q     <= digits_d;
            valid_q      <= valid_d;
            update_q     <= update_d;
            update_idx_q <= update_idx_d;
            bad_q        <= bad_d;
            err_q        <= err_d;
        end
    end

    assign digits      = digits_q;
    assign digit_valid = valid_q;
    assign update      = update_q;
    assign update_idx  = update_idx_q;
    assign bad_pattern = bad_q;
    assign err_sticky  = err_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_reader
//   Directed bench for seven_seg_reader (NUM_DIGITS=4, STABLE_CYCLES=4).
//   Inputs change 1 time unit after a rising edge; outputs are checked at the
//   same point, so a tuple driven before edge E is checked for commit after
//   edge E+4.
// -----------------------------------------------------------------------------
module tb_seven_seg_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  seg_n = 7'h7F;
    logic [3:0]  digit_en_n = 4'hF;
    logic        clear = 1'b0;
    logic [15:0] digits;
    logic [3:0]  digit_valid;
    logic        update;
    logic [1:0]  update_idx;
    logic        bad_pattern;
    logic        err_sticky;

    int tests = 0;
    int fails = 0;

    seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .digit_en_n  (digit_en_n),
        .clear       (clear),
        .digits      (digits),
        .digit_valid (digit_valid),
        .update      (update),
        .update_idx  (update_idx),
        .bad_pattern (bad_pattern),
        .err_sticky  (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] en, input logic [6:0] sn);
        digit_en_n = en;
        seg_n      = sn;
    endtask

    task automatic go_idle();
        drive(4'hF, 7'h7F);
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        repeat (2) tick();
        tests++;
        if ({digits, digit_valid, update, update_idx, bad_pattern, err_sticky} !== 26'd0) begin
            fails++;
            $display("FAIL reset_outputs: got digits=%h valid=%b upd=%b idx=%0d bad=%b err=%b, expected all zero",
                     digits, digit_valid, update, update_idx, bad_pattern, err_sticky);
        end
        rst_n = 1'b1;
        repeat (2) tick();
        $display("[TB] reset: digits=%h valid=%b", digits, digit_valid);
    endtask

    task automatic test_legal_commit();
        int pulses;
        drive(4'b1110, 7'b0110000);       // "3" on digit 0
        repeat (4) tick();                // edges E..E+3
        tests++;
        if (update !== 1'b0 || digit_valid !== 4'b0000) begin
            fails++;
            $display("FAIL legal_early: got upd=%b valid=%b at E+3, expected upd=0 valid=0000", update, digit_valid);
        end
        tick();                           // edge E+4
        tests++;
        if (update !== 1'b1 || update_idx !== 2'd0) begin
            fails++;
            $display("FAIL legal_update: got upd=%b idx=%0d, expected upd=1 idx=0", update, update_idx);
        end
        tests++;
        if (digits[3:0] !== 4'h3 || digit_valid !== 4'b0001 || bad_pattern !== 1'b0) begin
            fails++;
            $display("FAIL legal_value: got d0=%h valid=%b bad=%b, expected d0=3 valid=0001 bad=0",
                     digits[3:0], digit_valid, bad_pattern);
        end
        pulses = 0;
        repeat (3) begin
            tick();
            pulses += int'(update);
        end
        tests++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL legal_single_pulse: got %0d extra pulses, expected 0", pulses);
        end
        $display("[TB] legal_commit: digits=%h valid=%b", digits, digit_valid);
        go_idle();
    endtask

    task automatic test_glitch();
        int pulses = 0;
        drive(4'b1011, 7'b0000000);       // "8" on digit 2, only 3 cycles
        repeat (3) tick();
        drive(4'b1111, 7'b0000000);
        repeat (6) begin
            tick();
            pulses += int'(update) + int'(bad_pattern);
        end
        tests++;
        if (pulses != 0 || digit_valid !== 4'b0001) begin
            fails++;
            $display("FAIL glitch: got pulses=%0d valid=%b, expected pulses=0 valid=0001", pulses, digit_valid);
        end
        $display("[TB] glitch: valid=%b", digit_valid);
        go_idle();
    endtask

    task automatic test_illegal();
        drive(4'b1101, 7'b0111111);       // g only on digit 1
        repeat (4) tick();
        tests++;
        if (bad_pattern !== 1'b0 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL illegal_early: got bad=%b err=%b at E+3, expected 0 0", bad_pattern, err_sticky);
        end
        tick();
        tests++;
        if (bad_pattern !== 1'b1 || update !== 1'b0 || update_idx !== 2'd1) begin
            fails++;
            $display("FAIL illegal_pulse: got bad=%b upd=%b idx=%0d, expected bad=1 upd=0 idx=1",
                     bad_pattern, update, update_idx);
        end
        tests++;
        if (err_sticky !== 1'b1 || digit_valid !== 4'b0001) begin
            fails++;
            $display("FAIL illegal_state: got err=%b valid=%b, expected err=1 valid=0001", err_sticky, digit_valid);
        end
        tick();
        tests++;
        if (bad_pattern !== 1'b0 || err_sticky !== 1'b1 || update_idx !== 2'd1) begin
            fails++;
            $display("FAIL illegal_sticky: got bad=%b err=%b idx=%0d, expected bad=0 err=1 idx=1",
                     bad_pattern, err_sticky, update_idx);
        end
        go_idle();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tests++;
        if (err_sticky !== 1'b0 || digit_valid !== 4'b0000 || digits !== 16'h0000) begin
            fails++;
            $display("FAIL clear: got err=%b valid=%b digits=%h, expected err=0 valid=0000 digits=0000",
                     err_sticky, digit_valid, digits);
        end
        $display("[TB] illegal_then_clear: err=%b valid=%b", err_sticky, digit_valid);
    endtask

    task automatic test_blank();
        int pulses = 0;
        drive(4'b0111, 7'b0001110);       // "F" on digit 3
        repeat (5) tick();
        tests++;
        if (update !== 1'b1 || update_idx !== 2'd3 || digits[15:12] !== 4'hF || digit_valid !== 4'b1000) begin
            fails++;
            $display("FAIL blank_setup: got upd=%b idx=%0d d3=%h valid=%b, expected upd=1 idx=3 d3=F valid=1000",
                     update, update_idx, digits[15:12], digit_valid);
        end
        drive(4'b0111, 7'h7F);            // blank on the same digit
        repeat (6) begin
            tick();
            pulses += int'(update) + int'(bad_pattern);
        end
        tests++;
        if (pulses != 0 || digit_valid !== 4'b0000 || digits !== 16'hF000 || err_sticky !== 1'b0) begin
            fails++;
            $display("FAIL blank: got pulses=%0d valid=%b digits=%h err=%b, expected 0 0000 F000 0",
                     pulses, digit_valid, digits, err_sticky);
        end
        $display("[TB] blank: digits=%h valid=%b", digits, digit_valid);
        go_idle();
    endtask

    task automatic test_multi_hot();
        int pulses = 0;
        drive(4'b1100, 7'b0110000);
        repeat (10) begin
            tick();
            pulses += int'(update) + int'(bad_pattern);
        end
        tests++;
        if (pulses != 0 || digit_valid !== 4'b0000 || digits !== 16'hF000) begin
            fails++;
            $display("FAIL multi_hot: got pulses=%0d valid=%b digits=%h, expected 0 0000 F000",
                     pulses, digit_valid, digits);
        end
        $display("[TB] multi_hot: digits=%h valid=%b", digits, digit_valid);
        go_idle();
    endtask

    task automatic test_reset_mid_track();
        int pulses = 0;
        drive(4'b1101, 7'b0010010);       // "5" on digit 1
        repeat (3) tick();                // count has reached 2
        rst_n = 1'b0;
        #1;
        tests++;
        if (digits !== 16'h0000 || digit_valid !== 4'b0000) begin
            fails++;
            $display("FAIL midreset_async: got digits=%h valid=%b, expected 0000 0000", digits, digit_valid);
        end
        #1 rst_n = 1'b1;
        repeat (4) tick();                // E'..E'+3
        tests++;
        if (update !== 1'b0) begin
            fails++;
            $display("FAIL midreset_early: got upd=%b at E'+3, expected 0", update);
        end
        tick();
        tests++;
        if (update !== 1'b1 || update_idx !== 2'd1 || digits[7:4] !== 4'h5 || digit_valid !== 4'b0010) begin
            fails++;
            $display("FAIL midreset_commit: got upd=%b idx=%0d d1=%h valid=%b, expected 1 1 5 0010",
                     update, update_idx, digits[7:4], digit_valid);
        end
        $display("[TB] reset_mid_track: digits=%h valid=%b", digits, digit_valid);

        drive(4'b1011, 7'b0001000);       // "A" on digit 2
        repeat (4) tick();
        clear = 1'b1;                     // high across the commit edge
        tick();
        clear = 1'b0;
        tests++;
        if (update !== 1'b0 || bad_pattern !== 1'b0 || digit_valid !== 4'b0000 || digits !== 16'h0000) begin
            fails++;
            $display("FAIL clear_on_commit: got upd=%b bad=%b valid=%b digits=%h, expected 0 0 0000 0000",
                     update, bad_pattern, digit_valid, digits);
        end
        repeat (5) begin
            tick();
            pulses += int'(update) + int'(bad_pattern);
        end
        tests++;
        if (pulses != 0 || digit_valid !== 4'b0000) begin
            fails++;
            $display("FAIL clear_no_recommit: got pulses=%0d valid=%b, expected 0 0000", pulses, digit_valid);
        end
        $display("[TB] clear_on_commit: valid=%b", digit_valid);
    endtask

    initial begin
        test_reset();
        test_legal_commit();
        test_glitch();
        test_illegal();
        test_blank();
        test_multi_hot();
        test_reset_mid_track();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
